// File: rtl/jt900h_busarb.sv
// rtl/jt900h_busarb.sv - two-master 16-bit memory bus arbiter (JT900H_BUSARB_RR_EN selects round-robin)
module jt900h_busarb #(
    parameter int TIMEOUT = 255,
    parameter int STARVE  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [23:0] m0_addr,
    input  logic [15:0] m0_dout,
    input  logic [1:0]  m0_we,
    output logic [15:0] m0_din,
    output logic        m0_ack,
    output logic        m0_busy,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [23:0] m1_addr,
    input  logic [15:0] m1_dout,
    input  logic [1:0]  m1_we,
    output logic [15:0] m1_din,
    output logic        m1_ack,
    output logic        m1_busy,
    output logic        ram_cs,
    output logic [23:0] ram_addr,
    output logic [15:0] ram_dout,
    output logic [1:0]  ram_we,
    input  logic [15:0] ram_din,
    input  logic        ram_ok,
    output logic        buserror,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] tcnt;
    logic       win;
    logic       any_req;
    logic       lock_hit;

    assign m0_busy  = m0_req & ~m0_ack;
    assign m1_busy  = m1_req & ~m1_ack;
    assign any_req  = m0_req | m1_req;
    // The last owner keeps the bus only while it both holds lock and is still requesting
    assign lock_hit = owner ? (m1_lock & m1_req) : (m0_lock & m0_req);

`ifdef JT900H_BUSARB_RR_EN
    // Round-robin winner: on contention the port that did not own the bus last goes next
    always_comb begin
        win = 1'b0;
        if (lock_hit)
            win = owner;
        else if (m0_req && m1_req)
            win = ~owner;
        else
            win = m1_req;
    end
`else
    localparam logic [2:0] STARVE_MAX = 3'(STARVE);

    logic [2:0] starve_cnt;

    // Fixed-priority winner: lock, then forced port 0 when starved, then port 1 first
    always_comb begin
        win = 1'b0;
        if (lock_hit)
            win = owner;
        else if (starve_cnt == STARVE_MAX && m0_req)
            win = 1'b0;
        else
            win = m1_req;
    end

    // Starvation counter: port-1 grants that overtook a waiting port 0, cleared by any port-0 grant
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 3'd0;
        end else if (cen && state == IDLE && any_req) begin
            if (!win)
                starve_cnt <= 3'd0;
            else if (m0_req && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 3'd1;
        end
    end
`endif

    // Access sequencer: grant and drive the bus, wait for ram_ok or timeout, then acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tcnt     <= 8'd0;
            ram_cs   <= 1'b0;
            ram_addr <= 24'd0;
            ram_dout <= 16'd0;
            ram_we   <= 2'b00;
            m0_din   <= 16'd0;
            m1_din   <= 16'd0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            buserror <= 1'b0;
            owner    <= 1'b0;
        end else if (cen) begin
            case (state)
                IDLE: begin
                    m0_ack   <= 1'b0;
                    m1_ack   <= 1'b0;
                    buserror <= 1'b0;
                    if (any_req) begin
                        owner    <= win;
                        ram_cs   <= 1'b1;
                        ram_addr <= win ? m1_addr : m0_addr;
                        ram_dout <= win ? m1_dout : m0_dout;
                        ram_we   <= win ? m1_we   : m0_we;
                        tcnt     <= 8'd0;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ram_ok) begin
                        // Writes leave the read-data register of the owner untouched
                        if (ram_we == 2'b00) begin
                            if (owner)
                                m1_din <= ram_din;
                            else
                                m0_din <= ram_din;
                        end
                        ram_cs <= 1'b0;
                        ram_we <= 2'b00;
                        m0_ack <= ~owner;
                        m1_ack <= owner;
                        state  <= DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (tcnt + 8'd1 == TMAX) begin
                            if (owner)
                                m1_din <= 16'hFFFF;
                            else
                                m0_din <= 16'hFFFF;
                            buserror <= 1'b1;
                            ram_cs   <= 1'b0;
                            ram_we   <= 2'b00;
                            m0_ack   <= ~owner;
                            m1_ack   <= owner;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    m0_ack   <= 1'b0;
                    m1_ack   <= 1'b0;
                    buserror <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jt900h_busarb.sv
// tb/tb_jt900h_busarb.sv - scoreboard testbench for jt900h_busarb
module tb_jt900h_busarb;

    logic        clk = 1'b0;
    logic        rst, cen;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [23:0] m0_addr, m1_addr;
    logic [15:0] m0_dout, m1_dout;
    logic [1:0]  m0_we, m1_we;
    logic [15:0] m0_din, m1_din;
    logic        m0_ack, m1_ack, m0_busy, m1_busy;
    logic        ram_cs, ram_ok, buserror, owner;
    logic [23:0] ram_addr;
    logic [15:0] ram_dout, ram_din;
    logic [1:0]  ram_we;

    jt900h_busarb #(.TIMEOUT(8), .STARVE(4)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m0_we(m0_we), .m0_din(m0_din), .m0_ack(m0_ack), .m0_busy(m0_busy),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m1_we(m1_we), .m1_din(m1_din), .m1_ack(m1_ack), .m1_busy(m1_busy),
        .ram_cs(ram_cs), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_we(ram_we),
        .ram_din(ram_din), .ram_ok(ram_ok), .buserror(buserror), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        port;
        logic [23:0] addr;
        logic [15:0] dout;
        logic [1:0]  we;
        int          cyc;
    } grant_t;

    typedef struct packed {
        logic        port;
        logic [15:0] din;
        logic        berr;
        int          cyc;
    } done_t;

    grant_t got_g[$], exp_g[$];
    done_t  got_d[$], exp_d[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          cs_age;
    int          mem_delay;
    logic        mem_en;
    logic [15:0] mem_data;
    logic        cs_prev, ack0_prev, ack1_prev;

    // Memory model: cen cycles elapsed since chip select rose
    always @(posedge clk) begin
        if (rst)
            cs_age <= 0;
        else if (cen)
            cs_age <= ram_cs ? cs_age + 1 : 0;
    end

    function automatic grant_t mk_g(input logic p, input logic [23:0] a, input logic [15:0] d, input logic [1:0] w);
        grant_t g;
        g.port = p; g.addr = a; g.dout = d; g.we = w; g.cyc = 0;
        return g;
    endfunction

    function automatic done_t mk_d(input logic p, input logic [15:0] d, input logic b);
        done_t r;
        r.port = p; r.din = d; r.berr = b; r.cyc = 0;
        return r;
    endfunction

    // One clk period: posedge, then observe and drive memory inputs at the negedge
    task automatic step(input logic c);
        grant_t g;
        done_t  d;
        cen = c;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (ram_cs && !cs_prev) begin
            g = mk_g(owner, ram_addr, ram_dout, ram_we);
            g.cyc = cyc;
            got_g.push_back(g);
        end
        if (m0_ack && !ack0_prev) begin
            d = mk_d(1'b0, m0_din, buserror);
            d.cyc = cyc;
            got_d.push_back(d);
        end
        if (m1_ack && !ack1_prev) begin
            d = mk_d(1'b1, m1_din, buserror);
            d.cyc = cyc;
            got_d.push_back(d);
        end
        cs_prev   = ram_cs;
        ack0_prev = m0_ack;
        ack1_prev = m1_ack;
        ram_ok    = mem_en && ram_cs && (cs_age >= mem_delay);
        ram_din   = mem_data ^ ram_addr[15:0];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
        step(1'b1);
        step(1'b1);
        rst = 1'b0;
        got_g.delete(); got_d.delete(); exp_g.delete(); exp_d.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_req = 1'b1;
        step(1'b1);
        step(1'b1);
        n_cmp++;
        if ({ram_cs, ram_addr, ram_dout, ram_we} !== 43'd0) begin
            n_err++;
            $display("FAIL reset_ram: got cs=%b addr=%h dout=%h we=%b want all zero", ram_cs, ram_addr, ram_dout, ram_we);
        end
        n_cmp++;
        if ({m0_ack, m1_ack, m0_din, m1_din, buserror, owner} !== 36'd0) begin
            n_err++;
            $display("FAIL reset_ports: got ack=%b%b din0=%h din1=%h berr=%b owner=%b want all zero",
                     m0_ack, m1_ack, m0_din, m1_din, buserror, owner);
        end
        n_cmp++;
        if (m0_busy !== 1'b1 || m1_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got busy0=%b busy1=%b want 1 0", m0_busy, m1_busy);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        int t0;
        grant_t g, e;
        done_t  d, ed;
        do_reset();
        mem_en = 1'b1; mem_delay = 2; mem_data = 16'hBEEF ^ 16'h1234;
        m0_addr = 24'h001234; m0_we = 2'b00; m0_dout = 16'h0000; m0_req = 1'b1;
        exp_g.push_back(mk_g(1'b0, 24'h001234, 16'h0000, 2'b00));
        exp_d.push_back(mk_d(1'b0, 16'hBEEF, 1'b0));
        t0 = cyc;
        for (int k = 0; k < 40 && got_d.size() == 0; k++) begin
            step(1'b1);
            if (got_d.size() != 0) begin
                n_cmp++;
                if (m0_busy !== 1'b0 || owner !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_busy_owner: got busy=%b owner=%b want 0 0", m0_busy, owner);
                end
                m0_req = 1'b0;
            end
        end
        step(1'b1);
        n_cmp++;
        if (m0_ack !== 1'b0 || ram_cs !== 1'b0) begin
            n_err++;
            $display("FAIL single_ack_width: got ack=%b cs=%b want 0 0", m0_ack, ram_cs);
        end
        step(1'b1);
        n_cmp++;
        if (got_g.size() != 1 || got_d.size() != 1) begin
            n_err++;
            $display("FAIL single_count: got grants=%0d acks=%0d want 1 1", got_g.size(), got_d.size());
        end else begin
            g = got_g.pop_front(); e = exp_g.pop_front();
            d = got_d.pop_front(); ed = exp_d.pop_front();
            n_cmp++;
            if (g.port !== e.port || g.addr !== e.addr || g.we !== e.we) begin
                n_err++;
                $display("FAIL single_grant: got port=%0d addr=%h we=%b want port=%0d addr=%h we=%b",
                         g.port, g.addr, g.we, e.port, e.addr, e.we);
            end
            n_cmp++;
            if (d.port !== ed.port || d.din !== ed.din || d.berr !== ed.berr) begin
                n_err++;
                $display("FAIL single_done: got port=%0d din=%h berr=%b want port=%0d din=%h berr=%b",
                         d.port, d.din, d.berr, ed.port, ed.din, ed.berr);
            end
            n_cmp++;
            if (g.cyc - t0 != 1 || d.cyc - t0 != 4) begin
                n_err++;
                $display("FAIL single_latency: got cs=+%0d ack=+%0d want cs=+1 ack=+4", g.cyc - t0, d.cyc - t0);
            end
        end
    endtask

    task automatic test_contention();
        logic exp_port [7];
        grant_t g, e;
        done_t  d, ed;
        int     i;
`ifdef JT900H_BUSARB_RR_EN
        exp_port = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_port = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        do_reset();
        mem_en = 1'b1; mem_delay = 0; mem_data = 16'h5A00;
        m0_addr = 24'h000100; m0_we = 2'b00; m0_dout = 16'h0000;
        m1_addr = 24'h000200; m1_we = 2'b00; m1_dout = 16'h0000;
        for (int k = 0; k < 7; k++) begin
            exp_g.push_back(mk_g(exp_port[k], exp_port[k] ? 24'h000200 : 24'h000100, 16'h0000, 2'b00));
            exp_d.push_back(mk_d(exp_port[k], exp_port[k] ? 16'h5A00 ^ 16'h0200 : 16'h5A00 ^ 16'h0100, 1'b0));
        end
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 200 && got_d.size() < 7; k++) begin
            step(1'b1);
            if (got_d.size() >= 7) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step(1'b1); step(1'b1); step(1'b1);
        i = 0;
        while (exp_g.size() > 0) begin
            e = exp_g.pop_front(); ed = exp_d.pop_front();
            n_cmp++;
            if (got_g.size() == 0 || got_d.size() == 0) begin
                n_err++;
                $display("FAIL contention_missing %0d: got no grant/ack want port=%0d", i, e.port);
            end else begin
                g = got_g.pop_front(); d = got_d.pop_front();
                if (g.port !== e.port || g.addr !== e.addr || d.port !== ed.port || d.din !== ed.din) begin
                    n_err++;
                    $display("FAIL contention %0d: got port=%0d addr=%h ack=%0d din=%h want port=%0d addr=%h ack=%0d din=%h",
                             i, g.port, g.addr, d.port, d.din, e.port, e.addr, ed.port, ed.din);
                end
            end
            i++;
        end
        n_cmp++;
        if (got_g.size() != 0) begin
            n_err++;
            $display("FAIL contention_extra: got %0d extra grants want 0", got_g.size());
        end
    endtask

    task automatic test_lock();
        int     n_prev;
        int     i;
        grant_t g, e;
        done_t  d, ed;
        grant_t all_g[$];
        done_t  all_d[$];
        do_reset();
        mem_en = 1'b1; mem_delay = 1; mem_data = 16'h3C3C;
        m1_addr = 24'h000300; m1_we = 2'b00; m1_dout = 16'h0000; m1_req = 1'b1;
        m0_lock = 1'b1; m0_we = 2'b11; m0_addr = 24'h000A00; m0_dout = 16'hC000; m0_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_g.push_back(mk_g(1'b0, 24'h000A00 + 24'(k), 16'hC000 + 16'(k), 2'b11));
            exp_d.push_back(mk_d(1'b0, 16'h0000, 1'b0));
        end
        exp_g.push_back(mk_g(1'b1, 24'h000300, 16'h0000, 2'b00));
        exp_d.push_back(mk_d(1'b1, 16'h3C3C ^ 16'h0300, 1'b0));
        n_prev = 0;
        for (int k = 0; k < 200 && got_d.size() < 4; k++) begin
            step(1'b1);
            if (got_d.size() != n_prev) begin
                n_prev = got_d.size();
                if (n_prev < 3) begin
                    m0_addr = 24'h000A00 + 24'(n_prev); m0_dout = 16'hC000 + 16'(n_prev);
                end else if (n_prev == 3) begin
                    m0_lock = 1'b0; m0_addr = 24'h000A03; m0_dout = 16'hC003;
                end else begin
                    m0_req = 1'b0; m1_req = 1'b0;
                end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step(1'b1); step(1'b1);
        all_g = got_g; all_d = got_d;
        i = 0;
        while (exp_g.size() > 0) begin
            e = exp_g.pop_front(); ed = exp_d.pop_front();
            n_cmp++;
            if (got_g.size() == 0 || got_d.size() == 0) begin
                n_err++;
                $display("FAIL lock_missing %0d: got no grant/ack want port=%0d", i, e.port);
            end else begin
                g = got_g.pop_front(); d = got_d.pop_front();
                if (g.port !== e.port || g.addr !== e.addr || g.we !== e.we || g.dout !== e.dout ||
                    d.port !== ed.port || d.din !== ed.din) begin
                    n_err++;
                    $display("FAIL lock %0d: got port=%0d addr=%h we=%b dout=%h din=%h want port=%0d addr=%h we=%b dout=%h din=%h",
                             i, g.port, g.addr, g.we, g.dout, d.din, e.port, e.addr, e.we, e.dout, ed.din);
                end
            end
            i++;
        end
        n_cmp++;
        if (all_g.size() < 4 || all_d.size() < 3) begin
            n_err++;
            $display("FAIL lock_release: got grants=%0d acks=%0d want 4 grants", all_g.size(), all_d.size());
        end else if (all_g[3].cyc - all_d[2].cyc != 2) begin
            n_err++;
            $display("FAIL lock_release: got port-1 grant %0d cycles after ack want 2", all_g[3].cyc - all_d[2].cyc);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mem_en = 1'b0; mem_delay = 0; mem_data = 16'h7777;
        m0_addr = 24'h000040; m0_we = 2'b00; m0_dout = 16'h0000; m0_req = 1'b1;
        exp_d.push_back(mk_d(1'b0, 16'hFFFF, 1'b1));
        for (int k = 0; k < 60 && got_d.size() == 0; k++) begin
            step(1'b1);
            if (got_d.size() != 0) m0_req = 1'b0;
        end
        step(1'b1);
        n_cmp++;
        if (buserror !== 1'b0 || m0_ack !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_pulse_width: got berr=%b ack=%b want 0 0", buserror, m0_ack);
        end
        n_cmp++;
        if (got_g.size() != 1 || got_d.size() != 1) begin
            n_err++;
            $display("FAIL timeout_count: got grants=%0d acks=%0d want 1 1", got_g.size(), got_d.size());
        end else begin
            n_cmp++;
            if (got_d[0].din !== exp_d[0].din || got_d[0].berr !== exp_d[0].berr || got_d[0].port !== exp_d[0].port) begin
                n_err++;
                $display("FAIL timeout_done: got port=%0d din=%h berr=%b want port=0 din=ffff berr=1",
                         got_d[0].port, got_d[0].din, got_d[0].berr);
            end
            n_cmp++;
            if (got_d[0].cyc - got_g[0].cyc != 8) begin
                n_err++;
                $display("FAIL timeout_latency: got %0d want 8", got_d[0].cyc - got_g[0].cyc);
            end
        end
        got_g.delete(); got_d.delete(); exp_d.delete();
        mem_en = 1'b1; mem_delay = 7;
        m0_addr = 24'h000044; m0_req = 1'b1;
        exp_d.push_back(mk_d(1'b0, 16'h7777 ^ 16'h0044, 1'b0));
        for (int k = 0; k < 60 && got_d.size() == 0; k++) begin
            step(1'b1);
            if (got_d.size() != 0) m0_req = 1'b0;
        end
        step(1'b1);
        n_cmp++;
        if (got_g.size() != 1 || got_d.size() != 1) begin
            n_err++;
            $display("FAIL edge_count: got grants=%0d acks=%0d want 1 1", got_g.size(), got_d.size());
        end else begin
            n_cmp++;
            if (got_d[0].din !== exp_d[0].din || got_d[0].berr !== 1'b0 || got_d[0].cyc - got_g[0].cyc != 8) begin
                n_err++;
                $display("FAIL edge_ok_at_timeout: got din=%h berr=%b lat=%0d want din=%h berr=0 lat=8",
                         got_d[0].din, got_d[0].berr, got_d[0].cyc - got_g[0].cyc, exp_d[0].din);
            end
        end
    endtask

    task automatic test_cen_gating();
        int   ncen;
        int   ack_cen;
        logic c;
        do_reset();
        mem_en = 1'b1; mem_delay = 2; mem_data = 16'h1E1E;
        m0_addr = 24'h000ABC; m0_we = 2'b00; m0_dout = 16'h0000; m0_req = 1'b1;
        exp_d.push_back(mk_d(1'b0, 16'h1E1E ^ 16'h0ABC, 1'b0));
        ncen = 0;
        ack_cen = -1;
        for (int k = 0; k < 80 && got_d.size() == 0; k++) begin
            c = (k % 2 == 1);
            step(c);
            if (c) ncen++;
            if (got_d.size() != 0) begin
                ack_cen = ncen;
                m0_req = 1'b0;
            end
        end
        n_cmp++;
        if (ack_cen != 4) begin
            n_err++;
            $display("FAIL cen_latency: got ack after %0d cen cycles want 4", ack_cen);
        end
        step(1'b0);
        n_cmp++;
        if (m0_ack !== 1'b1) begin
            n_err++;
            $display("FAIL cen_ack_hold: got ack=%b with cen low want 1", m0_ack);
        end
        step(1'b1);
        n_cmp++;
        if (m0_ack !== 1'b0) begin
            n_err++;
            $display("FAIL cen_ack_drop: got ack=%b want 0", m0_ack);
        end
        n_cmp++;
        if (got_d.size() != 1 || got_d[0].din !== exp_d[0].din) begin
            n_err++;
            $display("FAIL cen_din: got acks=%0d din=%h want 1 ack din=%h", got_d.size(), m0_din, exp_d[0].din);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_en = 1'b0; mem_delay = 0; mem_data = 16'h4242;
        m0_addr = 24'h000010; m0_we = 2'b00; m0_dout = 16'h0000; m0_req = 1'b1;
        step(1'b1); step(1'b1); step(1'b1);
        n_cmp++;
        if (ram_cs !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre: got cs=%b want 1", ram_cs);
        end
        rst = 1'b1;
        step(1'b1);
        n_cmp++;
        if (ram_cs !== 1'b0 || m0_ack !== 1'b0 || buserror !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got cs=%b ack=%b berr=%b want 0 0 0", ram_cs, m0_ack, buserror);
        end
        rst = 1'b0;
        n_cmp++;
        if (got_d.size() != 0) begin
            n_err++;
            $display("FAIL mid_no_ack: got %0d acks want 0", got_d.size());
        end
        got_g.delete(); got_d.delete();
        mem_en = 1'b1; mem_delay = 1;
        for (int k = 0; k < 40 && got_d.size() == 0; k++) begin
            step(1'b1);
            if (got_d.size() != 0) m0_req = 1'b0;
        end
        step(1'b1);
        n_cmp++;
        if (got_g.size() != 1 || got_d.size() != 1) begin
            n_err++;
            $display("FAIL mid_recover_count: got grants=%0d acks=%0d want 1 1", got_g.size(), got_d.size());
        end else if (got_g[0].addr !== 24'h000010 || got_d[0].din !== (16'h4242 ^ 16'h0010) || got_d[0].berr !== 1'b0) begin
            n_err++;
            $display("FAIL mid_recover: got addr=%h din=%h berr=%b want addr=000010 din=%h berr=0",
                     got_g[0].addr, got_d[0].din, got_d[0].berr, 16'h4242 ^ 16'h0010);
        end
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1;
        m0_req = 1'b0; m0_lock = 1'b0; m0_addr = 24'd0; m0_dout = 16'd0; m0_we = 2'b00;
        m1_req = 1'b0; m1_lock = 1'b0; m1_addr = 24'd0; m1_dout = 16'd0; m1_we = 2'b00;
        ram_ok = 1'b0; ram_din = 16'd0;
        mem_en = 1'b0; mem_delay = 0; mem_data = 16'd0;
        cs_prev = 1'b0; ack0_prev = 1'b0; ack1_prev = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_lock();
        test_timeout();
        test_cen_gating();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
